// File: rtl/ofm_send_seq_pkg.sv
// Shared definitions for the output-feature-map send sequencer:
// FSM state encoding and default address/channel widths.
package ofm_send_seq_pkg;

  localparam int unsigned DEF_FM_ADDR_BIT = 12;
  localparam int unsigned DEF_CH_BIT      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ofm_send_seq_addr_cnt.sv
// Address/channel counter pair for the send sequencer. Walks addresses
// [start, end) for each channel group 0..ch_num, address innermost.
// On load it captures the job bounds so later input changes are ignored.
module ofm_addr_cnt
  import ofm_send_seq_pkg::*;
#(
  parameter int unsigned FM_ADDR_BIT = DEF_FM_ADDR_BIT,
  parameter int unsigned CH_BIT      = DEF_CH_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic [FM_ADDR_BIT-1:0] addr_start_i,
  input  logic [FM_ADDR_BIT-1:0] addr_end_i,
  input  logic [CH_BIT-1:0]      ch_num_i,
  output logic [FM_ADDR_BIT-1:0] addr_o,
  output logic [CH_BIT-1:0]      ch_o,
  output logic                   last_o
);

  logic [FM_ADDR_BIT-1:0] addr_q, addr_d;
  logic [FM_ADDR_BIT-1:0] start_q, start_d;
  logic [FM_ADDR_BIT-1:0] end_q, end_d;
  logic [CH_BIT-1:0]      ch_q, ch_d;
  logic [CH_BIT-1:0]      chn_q, chn_d;

  // One extra bit so addr+1 is compared against end without wrapping.
  logic [FM_ADDR_BIT:0] addr_inc;
  logic                 addr_at_end;
  logic                 wrap;

  assign addr_inc    = {1'b0, addr_q} + 1'b1;
  assign addr_at_end = (addr_inc >= {1'b0, end_q});
  assign wrap        = step_i & addr_at_end;

  assign addr_o = addr_q;
  assign ch_o   = ch_q;
  assign last_o = (addr_inc == {1'b0, end_q}) && (ch_q == chn_q);

  // Next-state: load job bounds, or step address with reload/channel advance.
  always_comb begin
    addr_d  = addr_q;
    start_d = start_q;
    end_d   = end_q;
    ch_d    = ch_q;
    chn_d   = chn_q;
    if (load_i) begin
      start_d = addr_start_i;
      end_d   = addr_end_i;
      chn_d   = ch_num_i;
      addr_d  = addr_start_i;
      ch_d    = '0;
    end else if (wrap) begin
      addr_d = start_q;
      ch_d   = ch_q + 1'b1;
    end else if (step_i) begin
      addr_d = addr_inc[FM_ADDR_BIT-1:0];
    end
  end

  // Counter and latched-bound registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      ch_q    <= '0;
      chn_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      start_q <= start_d;
      end_q   <= end_d;
      ch_q    <= ch_d;
      chn_q   <= chn_d;
    end
  end

endmodule

// File: rtl/ofm_send_seq.sv
// Output-feature-map send sequencer: on start, issues one read request per
// (address, channel group) with a valid/ready handshake, then pulses done.
// Optional macro OFM_SEND_STALL_CNT_EN adds a 32-bit saturating stall counter.
module ofm_send_seq
  import ofm_send_seq_pkg::*;
#(
  parameter int unsigned FM_ADDR_BIT = DEF_FM_ADDR_BIT,
  parameter int unsigned CH_BIT      = DEF_CH_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FM_ADDR_BIT-1:0] addr_start,
  input  logic [FM_ADDR_BIT-1:0] addr_end,
  input  logic [CH_BIT-1:0]      ch_num,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [FM_ADDR_BIT-1:0] rd_addr,
  output logic [CH_BIT-1:0]      rd_ch,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   done,
  output logic                   empty_err
`ifdef OFM_SEND_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   accept;
  logic   handshake;
  logic   job_empty;
  logic   cnt_last;

  assign job_empty = (addr_end <= addr_start);
  assign handshake = rd_valid & rd_ready;
  assign rd_last   = rd_valid & cnt_last;
  assign empty_err = err_q;

  ofm_addr_cnt #(
    .FM_ADDR_BIT (FM_ADDR_BIT),
    .CH_BIT      (CH_BIT)
  ) u_addr_cnt (
    .clk          (clk),
    .rst          (rst),
    .load_i       (accept),
    .step_i       (handshake),
    .addr_start_i (addr_start),
    .addr_end_i   (addr_end),
    .ch_num_i     (ch_num),
    .addr_o       (rd_addr),
    .ch_o         (rd_ch),
    .last_o       (cnt_last)
  );

  // FSM next-state and state-decoded outputs; empty jobs bypass SEND.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    accept   = 1'b0;
    rd_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (job_empty) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        rd_valid = 1'b1;
        busy     = 1'b1;
        if (rd_ready && cnt_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and sticky empty-job flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

`ifdef OFM_SEND_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_cnt = stall_q;

  // Stall count: cleared per job, counts valid-without-ready, saturates.
  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (rd_valid && !rd_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_ofm_send_seq.sv
// Self-checking bench for ofm_send_seq: table of directed jobs, hand-written
// busy/DONE-start and mid-job reset sequences, then randomized jobs. Every
// observed handshake is checked against a queue of expected requests built
// from the job parameters.
module tb_ofm_send_seq;

  localparam int AW = 12;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr_start;
  logic [AW-1:0] addr_end;
  logic [CW-1:0] ch_num;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_ch;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          empty_err;
`ifdef OFM_SEND_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  ofm_send_seq #(
    .FM_ADDR_BIT (AW),
    .CH_BIT      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .ch_num     (ch_num),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rd_ch      (rd_ch),
    .rd_last    (rd_last),
    .busy       (busy),
    .done       (done),
    .empty_err  (empty_err)
`ifdef OFM_SEND_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [CW-1:0] c;
    logic          last;
  } req_t;

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    logic [CW-1:0] c;
    int            mode;     // 0: ready=1, 1: toggle 1/0, 2: random
    int            exp_req;
  } vec_t;

  req_t exp_q[$];
  req_t prev;
  logic prev_stall;
  logic exp_err;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt;
  int   vcyc;
  int   done_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected request stream: every address of [s,e) for each channel group.
  task automatic build_model(input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic [CW-1:0] c);
    exp_q.delete();
    if (e > s) begin
      for (int ch = 0; ch <= int'(c); ch++) begin
        for (int a = int'(s); a < int'(e); a++) begin
          exp_q.push_back('{AW'(a), CW'(ch), (a == int'(e) - 1) && (ch == int'(c))});
        end
      end
    end
  endtask

  // Observe one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    req_t r;
    @(negedge clk);
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_hold_valid", rd_valid, 1'b1);
        chk("stall_hold_addr", rd_addr, prev.a);
        chk("stall_hold_ch", rd_ch, prev.c);
        chk("stall_hold_last", rd_last, prev.last);
      end
      if (rd_valid) begin
        vcyc++;
        chk("busy_with_valid", busy, 1'b1);
        if (rd_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %0d ch %0d, expected no request", rd_addr, rd_ch);
          end else begin
            r = exp_q.pop_front();
            chk("req_addr", rd_addr, r.a);
            chk("req_ch", rd_ch, r.c);
            chk("req_last", rd_last, r.last);
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_in_done", busy, 1'b0);
        chk("valid_in_done", rd_valid, 1'b0);
      end
      prev_stall = rd_valid & ~rd_ready;
      prev = '{rd_addr, rd_ch, rd_last};
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the job, scramble inputs afterwards, run until done.
  task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] e,
                         input logic [CW-1:0] c, input int mode, input int exp_req,
                         input bit junk_start, input string tag);
    logic got;
    build_model(s, e, c);
    if (!(e > s)) exp_err = 1'b1;
    hs_cnt = 0;
    vcyc = 0;
    done_cnt = 0;
    start = 1'b1;
    addr_start = s;
    addr_end = e;
    ch_num = c;
    tick();
    if (e > s) chk({tag, "_busy_after_accept"}, busy, 1'b1);
    else       chk({tag, "_done_after_accept"}, done, 1'b1);
    start = junk_start;
    addr_start = AW'($urandom);
    addr_end = AW'($urandom);
    ch_num = CW'($urandom);
    got = 1'b0;
    for (int k = 0; k < 4000 && !got; k++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      got = done;
      tick();
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_req_count"}, hs_cnt, exp_req);
    chk({tag, "_model_left"}, exp_q.size(), 0);
    if (mode == 0) chk({tag, "_throughput"}, vcyc, exp_req);
    chk({tag, "_empty_err"}, empty_err, exp_err);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_done"}, done, 1'b0);
`ifdef OFM_SEND_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, stall_cnt, vcyc - hs_cnt);
`endif
    start = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{12'd0,    12'd4,    6'd1, 0, 8};
    vecs[1] = '{12'd16,   12'd18,   6'd0, 1, 2};
    vecs[2] = '{12'd5,    12'd5,    6'd0, 0, 0};
    vecs[3] = '{12'd4094, 12'd4095, 6'd0, 0, 1};
    vecs[4] = '{12'd10,   12'd7,    6'd2, 2, 0};
    vecs[5] = '{12'd100,  12'd103,  6'd3, 2, 12};
    vecs[6] = '{12'd0,    12'd1,    6'd0, 0, 1};
    vecs[7] = '{12'd4090, 12'd4095, 6'd2, 1, 15};

    rst = 1'b1;
    start = 1'b0;
    addr_start = '0;
    addr_end = '0;
    ch_num = '0;
    rd_ready = 1'b0;
    prev_stall = 1'b0;
    exp_err = 1'b0;
    prev = '{'0, '0, 1'b0};
    repeat (3) tick();
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_ch", rd_ch, 0);
    chk("rst_last", rd_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_empty_err", empty_err, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].s, vecs[i].e, vecs[i].c, vecs[i].mode, vecs[i].exp_req, 1'b0,
              $sformatf("vec%0d", i));
`ifdef OFM_SEND_STALL_CNT_EN
      if (i == 1) chk("vec1_stall_is_one", stall_cnt, 1);
`endif
      tick();
    end

    // start held high while busy and through the DONE cycle must not restart.
    run_job(12'd0, 12'd3, 6'd0, 0, 3, 1'b1, "busy_start");
    // run_job left us in the IDLE cycle right after DONE: this start is taken.
    run_job(12'd200, 12'd202, 6'd0, 0, 2, 1'b0, "after_done_start");

    // Mid-job reset after three handshakes.
    build_model(12'd0, 12'd100, 6'd0);
    hs_cnt = 0;
    start = 1'b1;
    addr_start = 12'd0;
    addr_end = 12'd100;
    ch_num = 6'd0;
    rd_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && hs_cnt < 3; k++) tick();
    chk("midrst_reached_3", hs_cnt, 3);
    rst = 1'b1;
    tick();
    chk("midrst_valid", rd_valid, 1'b0);
    chk("midrst_addr", rd_addr, 0);
    chk("midrst_ch", rd_ch, 0);
    chk("midrst_last", rd_last, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_empty_err", empty_err, 1'b0);
`ifdef OFM_SEND_STALL_CNT_EN
    chk("midrst_stall", stall_cnt, 0);
`endif
    rst = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    vcyc = 0;
    repeat (6) tick();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_valid", vcyc, 0);

    // Randomized jobs.
    for (int i = 0; i < 30; i++) begin
      logic [AW-1:0] s;
      logic [AW-1:0] e;
      logic [CW-1:0] c;
      int            n;
      s = AW'($urandom_range(0, 4080));
      if ($urandom_range(0, 5) == 0) e = AW'($urandom_range(0, int'(s)));
      else                           e = s + AW'($urandom_range(1, 7));
      c = CW'($urandom_range(0, 3));
      n = (e > s) ? int'(e - s) * (int'(c) + 1) : 0;
      run_job(s, e, c, int'($urandom_range(0, 2)), n, 1'($urandom_range(0, 1)),
              $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_send_seq.md
OFM_SEND_SEQ -- requirements
Module: ofm_send_seq

Interface
REQ-001 SHALL have parameter FM_ADDR_BIT, default 12, feature-map address width.
REQ-002 SHALL have parameter CH_BIT, default 6, channel-group counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a send job.
REQ-006 SHALL have port addr_start  input  FM_ADDR_BIT  first address, inclusive.
REQ-007 SHALL have port addr_end  input  FM_ADDR_BIT  last address, exclusive.
REQ-008 SHALL have port ch_num  input  CH_BIT  number of channel groups minus 1.
REQ-009 SHALL have port rd_valid  output  1  rd_addr/rd_ch hold a valid read request.
REQ-010 SHALL have port rd_ready  input  1  downstream accepts the request this cycle.
REQ-011 SHALL have port rd_addr  output  FM_ADDR_BIT  output-buffer read address.
REQ-012 SHALL have port rd_ch  output  CH_BIT  channel-group (bank) select.
REQ-013 SHALL have port rd_last  output  1  marks the final request of the job.
REQ-014 SHALL have port busy  output  1  high from job acceptance until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-016 SHALL have port empty_err  output  1  sticky flag: a job had addr_end <= addr_start.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, DONE.
REQ-018 IDLE: on start, SHALL latch addr_start, addr_end, ch_num; load rd_addr=addr_start, rd_ch=0; enter SEND next cycle with busy=1.
REQ-019 start SHALL be ignored while busy=1; inputs changing after latching SHALL have no effect.
REQ-020 SEND: rd_valid SHALL be 1; rd_addr/rd_ch/rd_last SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-021 On handshake (rd_valid & rd_ready): if rd_addr+1 < latched end, rd_addr increments; else rd_addr reloads latched start and rd_ch increments.
REQ-022 Order SHALL be address-inner, channel-outer; total requests = (end-start)*(ch_num+1).
REQ-023 rd_last SHALL be 1 exactly when rd_addr = end-1 and rd_ch = ch_num.
REQ-024 Handshake with rd_last=1 SHALL move to DONE; rd_valid drops the next cycle.
REQ-025 DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
REQ-026 If latched addr_end <= addr_start, SHALL skip SEND, go IDLE->DONE, issue no request, set empty_err.
REQ-027 Address comparison SHALL be unsigned at FM_ADDR_BIT; increment never wraps past end.
REQ-028 A start in the DONE cycle SHALL be ignored; a start one cycle later SHALL be accepted.
REQ-029 Throughput SHALL be one request per cycle with rd_ready held 1.

Reset
REQ-030 rst SHALL force IDLE, rd_valid=0, rd_addr=0, rd_ch=0, rd_last=0, busy=0, done=0, empty_err=0, including mid-job; no further requests.

Configuration
REQ-031 With macro OFM_SEND_STALL_CNT_EN defined, SHALL add output stall_cnt (32 bit), counting cycles with rd_valid=1 and rd_ready=0, cleared on job acceptance and rst, saturating at max.
REQ-032 Without OFM_SEND_STALL_CNT_EN, stall_cnt port and logic SHALL be absent; other behaviour identical.

Structure
REQ-033 Shared package SHALL hold FSM state encoding (IDLE=0, SEND=1, DONE=2) and defaults FM_ADDR_BIT=12, CH_BIT=6.
REQ-034 The address/channel counter pair SHALL be one sub-module, ofm_addr_cnt (load, step, wrap, last flag); FSM stays in top.

Verification
REQ-035 start, start=0, end=4, ch_num=1, rd_ready=1 -> addrs 0,1,2,3,0,1,2,3; rd_ch 0x4,1x4; rd_last on 8th; done 1 cycle later.
REQ-036 start=16, end=18, ch_num=0, rd_ready toggling 1/0 -> addresses 16,17 each held while stalled; stall_cnt=1 when macro defined.
REQ-037 start=5, end=5 -> no rd_valid, done 1 cycle after IDLE->DONE, empty_err=1 until rst.
REQ-038 second start pulses while busy and in DONE cycle -> ignored; start one cycle after done -> accepted.
REQ-039 rst asserted after 3 handshakes of start=0, end=100 job -> next cycle all outputs zero, IDLE, no done pulse.
REQ-040 start=4094, end=4095, ch_num=0 (FM_ADDR_BIT=12) -> one request at 4094 with rd_last=1, no wrap to 0.
